// File: rtl/cpu_pkg.sv
// Shared CPU control-section types: fetch FSM states, fetch queue entry and the NOP encoding.
package cpu_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE,
        FETCH_REQUEST,
        FETCH_WAIT,
        FETCH_DISCARD,
        FETCH_HALT
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry instruction FIFO between the fetch FSM and the decoder; push/pop/flush with count.
module fetch_queue
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head_entry,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    fetch_entry_t entries [2];
    logic         head;
    logic         tail;
    logic         do_push;
    logic         do_pop;

    assign full       = (count == 2'd2);
    assign empty      = (count == 2'd0);
    assign do_pop     = pop && !empty;
    assign do_push    = push && (!full || do_pop);
    // With both slots occupied the tail wraps onto the head slot, which a same-cycle pop frees.
    assign tail       = head ^ count[0];
    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (reset) begin
            head       <= 1'b0;
            count      <= 2'd0;
            entries[0] <= '0;
            entries[1] <= '0;
        end else if (flush) begin
            head  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) begin
                entries[tail] <= push_entry;
            end
            if (do_pop) begin
                head <= ~head;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC, single-outstanding imem handshake, redirect flush, 2-entry decode queue.
// Optional INSTRUCTION_FETCH_ALIGN_CHECK_EN adds the sticky fetch_misaligned flag on unaligned redirects.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_error,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    output logic        inst_fault,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_misaligned
`endif
);

    fetch_state_t state;
    fetch_state_t redirect_state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic [31:0]  target;
    logic         accept;
    logic         push;
    logic         pop;
    logic         q_full;
    logic         q_empty;
    logic [1:0]   q_count;
    fetch_entry_t push_entry;
    fetch_entry_t head_entry;

    // Nothing is outstanding in REQUEST, so a full queue alone blocks a new request.
    assign imem_req_valid = (state == FETCH_REQUEST) && !q_full;
    assign imem_addr      = pc;
    assign accept         = imem_req_valid && imem_req_ready;
    assign target         = redirect_target & 32'hFFFF_FFFC;

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (redirect_target[1:0] != 2'b00);
`endif

    assign push       = (state == FETCH_WAIT) && imem_resp_valid && !redirect_valid && !reset;
    assign pop        = !q_empty && inst_ready;
    assign push_entry = '{pc: req_pc, word: imem_resp_data, fault: imem_resp_error};

    // A response landing together with the redirect retires the outstanding request, so no DISCARD.
    always_comb begin
        redirect_state = FETCH_REQUEST;
        case (state)
            FETCH_WAIT, FETCH_DISCARD: if (!imem_resp_valid) redirect_state = FETCH_DISCARD;
            FETCH_REQUEST:             if (accept)           redirect_state = FETCH_DISCARD;
            default:                   redirect_state = FETCH_REQUEST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= FETCH_IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            fetch_misaligned <= 1'b0;
`endif
        end else if (redirect_valid) begin
            pc    <= target;
            state <= redirect_state;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
            fetch_misaligned <= misaligned;
            if (misaligned) begin
                state <= FETCH_HALT;
            end
`endif
        end else begin
            case (state)
                FETCH_IDLE: state <= FETCH_REQUEST;
                FETCH_REQUEST: begin
                    if (accept) begin
                        req_pc <= pc;
                        pc     <= pc + 32'd4;
                        state  <= FETCH_WAIT;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_resp_valid) begin
                        state <= imem_resp_error ? FETCH_HALT : FETCH_REQUEST;
                    end
                end
                FETCH_DISCARD: begin
                    if (imem_resp_valid) begin
                        state <= FETCH_REQUEST;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    fetch_queue u_fetch_queue (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head_entry),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign inst_valid = (q_count != 2'd0);

    always_comb begin
        instruction = '0;
        inst_pc     = '0;
        inst_fault  = 1'b0;
        if (!q_empty) begin
            inst_pc     = head_entry.pc;
            inst_fault  = head_entry.fault;
            instruction = head_entry.fault ? NOP_INSTRUCTION : head_entry.word;
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Front end of the CPU control section. Holds the program counter, issues word reads to instruction memory over a request/response handshake, and buffers returned words with their PCs in a 2-entry queue. The queue drives the instruction decoder over a valid/ready handshake. Redirects from the execute stage (branch, jump, trap) flush in-flight work and restart fetching at the new target.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request pending.
- imem_req_ready  input  1  memory accepts the request this cycle.
- imem_addr  output  32  fetch address (word aligned).
- imem_resp_valid  input  1  response word present.
- imem_resp_data  input  32  fetched instruction word.
- imem_resp_error  input  1  access fault on this response.
- inst_valid  output  1  instruction and inst_pc valid toward the decoder.
- inst_ready  input  1  decoder consumes the head entry.
- instruction  output  32  instruction word for the decoder.
- inst_pc  output  32  address of that instruction.
- inst_fault  output  1  head entry carries an access fault; instruction reads 32'h0000_0013 (NOP).
- redirect_valid  input  1  flush and restart.
- redirect_target  input  32  new fetch address.
- fetch_misaligned  output  1  present only with the macro; see Configuration.

## Operation
- States:
  - IDLE: entered on reset; moves to REQUEST on the next cycle.
  - REQUEST: imem_req_valid=1. On acceptance (valid&&ready), pc<=pc+4 with mod-2^32 wrap, then go to WAIT.
  - WAIT: awaiting a response.
  - DISCARD: a stale response is outstanding and must be dropped.
  - HALT: fetch stopped after a fault.
- Maximum one outstanding request. REQUEST holds imem_req_valid low while (queue count + outstanding) == 2.
- Response in WAIT: push {imem_resp_data, imem_addr_of_request, imem_resp_error}.
  - Error clear: go to REQUEST.
  - Error set: go to HALT.
- Queue: 2 entries with a head pointer. The head is popped when inst_valid&&inst_ready. Push and pop in the same cycle are allowed when the queue is full.
- Redirect has priority over every other event:
  - Queue cleared and pc<=redirect_target.
  - From WAIT, or from REQUEST with acceptance in the same cycle: go to DISCARD.
  - From all other states: go to REQUEST.
- DISCARD: the next response is dropped, then go to REQUEST. A response arriving in the same cycle as a new redirect is dropped, and the state goes directly to REQUEST.
- Redirect while a request is unaccepted: the request is withdrawn. The memory must not rely on valid persisting across a redirect.

## Timing
- Reset values:
  - imem_req_valid=0, inst_valid=0, inst_fault=0, fetch_misaligned=0.
  - imem_addr=RESET_PC, instruction=0, inst_pc=0.
  - Queue empty, state IDLE.
- imem_req_valid first asserts 1 cycle after reset deasserts.
- imem_addr stays stable while valid&&!ready, except on redirect.
- Responses arrive at the earliest 1 cycle after acceptance.
- A response pushed at edge N gives inst_valid=1 from cycle N+1. Best throughput is 1 instruction per 2 cycles with single-cycle memory.
- Redirect at edge N: inst_valid=0 in cycle N+1, and imem_addr=target in cycle N+1.
- Reset asserted mid-operation discards everything. Any response that arrives later is ignored: the state is IDLE/REQUEST and nothing is outstanding.

## Configuration
- INSTRUCTION_FETCH_ALIGN_CHECK_EN:
  - Defined: a redirect_target with [1:0]!=0 sets fetch_misaligned=1 (sticky) and moves to HALT. The next aligned redirect clears the flag.
  - Undefined: the fetch_misaligned port is absent, and target[1:0] is forced to 0.

## Structure
- Shared package `cpu_pkg`:
  - fetch state enum.
  - NOP constant 32'h0000_0013.
  - queue entry struct {pc, word, fault}.
- One sub-module, `fetch_queue`: the 2-entry FIFO with push/pop/flush, count, full and empty.

## Test plan
- Reset with RESET_PC=32'h100, memory always ready with 1-cycle latency -> requests at 0x100, 0x104, 0x108. The decoder sees matching inst_pc, with inst_valid first high 3 cycles after reset release.
- inst_ready held 0 -> after two responses imem_req_valid stays 0. Then hold ready=1 -> entries drain in order and fetching resumes.
- Redirect to 0x200 during WAIT -> the pending response (word 0xDEADBEEF) is never presented. The next inst_pc is 0x200.
- Response with imem_resp_error=1 at 0x10C -> inst_fault=1, instruction=0x13, inst_pc=0x10C, no further requests. A redirect to 0x0 resumes fetching.
- PC 0xFFFF_FFFC -> the next fetch address is 0x0000_0000.
- Macro defined, redirect to 0x202 -> fetch_misaligned=1 and no requests. A redirect to 0x300 clears the flag and fetching resumes.
